prio_bitscan_encoder: RTL

//  Parametrised successor to the 8-to-3 encoder. Accepts an N-bit request vector
//  and emits the binary index of every set bit, one index per beat, in priority

---
 rtl/prio_bitscan_encoder.sv | 111 +++++++++++
 1 files changed

// File: rtl/prio_bitscan_encoder.sv
// rtl/prio_bitscan_encoder.sv - multi-beat priority bit-scan encoder with valid/ready handshakes
module prio_bitscan_encoder #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_zero
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic           zero_q, zero_d;

    logic [W-1:0]   prio_idx;
    logic [N-1:0]   prio_mask;
    logic           one_hot;

    // Priority pick over the pending bits; the later loop iteration wins, so
    // iteration order decides whether the highest or lowest set bit is chosen.
    always_comb begin
        prio_idx  = '0;
        prio_mask = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (pending_q[i]) begin
                    prio_idx  = i[W-1:0];
                    prio_mask = '0;
                    prio_mask[i] = 1'b1;
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pending_q[i]) begin
                    prio_idx  = i[W-1:0];
                    prio_mask = '0;
                    prio_mask[i] = 1'b1;
                end
            end
        end
    end

    // A nonzero vector with no second set bit is on its final beat.
    always_comb begin
        one_hot = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_SCAN);
        out_idx   = prio_idx;
        out_last  = one_hot || zero_q;
        out_zero  = zero_q;
    end

    // Next-state logic: load in IDLE, retire one bit per accepted beat in SCAN.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    pending_d = in_vec;
                    zero_d    = (in_vec == '0);
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    pending_d = pending_q & ~prio_mask;
                    if (out_last) begin
                        state_d = ST_IDLE;
                        zero_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any scan in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

endmodule
